// File: rtl/pc_unit.sv
//==============================================================================
// Module      : pc_unit
// Description : Fetch program counter with BOOT/RUN/HALT control, redirect,
//               trap vectoring and misaligned-target detection. Defining
//               PC_RAS_EN adds a circular return-address stack.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module pc_unit #(
    parameter int              XLEN         = 32,
    parameter int              INC          = 4,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
    parameter int              ALIGN_BITS   = 2,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            clr_n,
    input  logic            stall,
    input  logic            redirect_en,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            trap_en,
    input  logic            halt_req,
    input  logic            resume,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_next_seq,
    output logic            pc_valid,
    output logic            misalign
`ifdef PC_RAS_EN
    ,
    input  logic            ras_call,
    input  logic            ras_ret,
    output logic            ras_empty
`endif
);

    localparam logic [XLEN-1:0] c_inc = XLEN'(INC);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_nxt;
    logic [XLEN-1:0] w_pc_seq;
    logic            r_valid;
    logic            r_misalign;
    logic            w_misalign_nxt;
    logic            w_misaligned_tgt;

    assign w_pc_seq = r_pc + c_inc;

    generate
        if (ALIGN_BITS > 0) begin : g_align_chk
            assign w_misaligned_tgt = |redirect_pc[ALIGN_BITS-1:0];
        end else begin : g_no_align_chk
            assign w_misaligned_tgt = 1'b0;
        end
    endgenerate

`ifdef PC_RAS_EN
    localparam int c_ptr_w = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int c_cnt_w = $clog2(RAS_DEPTH + 1);

    logic [XLEN-1:0]    r_ras_mem [RAS_DEPTH];
    logic [c_ptr_w-1:0] r_ras_ptr;
    logic [c_cnt_w-1:0] r_ras_cnt;
    logic [c_ptr_w-1:0] w_ras_top_idx;
    logic [c_ptr_w-1:0] w_ras_ptr_inc;
    logic [XLEN-1:0]    w_ras_top;
    logic               w_ras_empty;
    logic               w_ras_full;
    logic               w_ras_push;
    logic               w_ras_pop;
    logic               w_ras_swap;
    logic               w_ras_clear;

    // r_ras_ptr names the next free slot; the top entry sits just below it.
    assign w_ras_top_idx = (r_ras_ptr == '0) ? c_ptr_w'(RAS_DEPTH - 1) : r_ras_ptr - 1'b1;
    assign w_ras_ptr_inc = (r_ras_ptr == c_ptr_w'(RAS_DEPTH - 1)) ? '0 : r_ras_ptr + 1'b1;
    assign w_ras_top     = r_ras_mem[w_ras_top_idx];
    assign w_ras_empty   = (r_ras_cnt == '0);
    assign w_ras_full    = (r_ras_cnt == c_cnt_w'(RAS_DEPTH));
    assign ras_empty     = w_ras_empty;
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_misalign_nxt = 1'b0;
`ifdef PC_RAS_EN
        w_ras_push     = 1'b0;
        w_ras_pop      = 1'b0;
        w_ras_swap     = 1'b0;
        w_ras_clear    = 1'b0;
`endif
        if (trap_en) begin
            w_state_nxt = S_RUN;
            w_pc_nxt    = TRAP_VECTOR;
`ifdef PC_RAS_EN
            w_ras_clear = 1'b1;
`endif
        end else begin
            case (r_state)
                S_BOOT: begin
                    w_state_nxt = S_RUN;
                end
                S_HALT: begin
                    if (resume) begin
                        w_state_nxt = S_RUN;
                    end
                end
                S_RUN: begin
                    if (halt_req) begin
                        w_state_nxt = S_HALT;
                    end else if (redirect_en) begin
                        if (w_misaligned_tgt) begin
                            w_pc_nxt       = TRAP_VECTOR;
                            w_misalign_nxt = 1'b1;
                        end else begin
                            w_pc_nxt = redirect_pc;
                        end
                    end
`ifdef PC_RAS_EN
                    else if (ras_ret && !w_ras_empty) begin
                        w_pc_nxt = w_ras_top;
                        if (ras_call) begin
                            w_ras_swap = 1'b1;
                        end else begin
                            w_ras_pop  = 1'b1;
                        end
                    end
`endif
                    else if (!stall) begin
                        w_pc_nxt = w_pc_seq;
`ifdef PC_RAS_EN
                        w_ras_push = ras_call;
`endif
                    end
                end
                default: begin
                    w_state_nxt = S_BOOT;
                end
            endcase
        end
    end

    always_ff @(negedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state    <= S_BOOT;
            r_pc       <= RESET_VECTOR;
            r_valid    <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_valid    <= (w_state_nxt == S_RUN);
            r_misalign <= w_misalign_nxt;
        end
    end

`ifdef PC_RAS_EN
    always_ff @(negedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_ras_ptr <= '0;
            r_ras_cnt <= '0;
        end else if (w_ras_clear) begin
            r_ras_ptr <= '0;
            r_ras_cnt <= '0;
        end else if (w_ras_push) begin
            // A full stack wraps onto its oldest entry, so the count saturates.
            r_ras_ptr <= w_ras_ptr_inc;
            if (!w_ras_full) begin
                r_ras_cnt <= r_ras_cnt + 1'b1;
            end
        end else if (w_ras_pop) begin
            r_ras_ptr <= w_ras_top_idx;
            r_ras_cnt <= r_ras_cnt - 1'b1;
        end
    end

    always_ff @(negedge clk) begin
        if (w_ras_push) begin
            r_ras_mem[r_ras_ptr] <= w_pc_seq;
        end else if (w_ras_swap) begin
            r_ras_mem[w_ras_top_idx] <= w_pc_seq;
        end
    end
`endif

    assign pc          = r_pc;
    assign pc_next_seq = w_pc_seq;
    assign pc_valid    = r_valid;
    assign misalign    = r_misalign;

endmodule

`default_nettype wire

// File: tb/tb_pc_unit.sv
//==============================================================================
// Module      : tb_pc_unit
// Description : Directed and random checks of pc_unit against a queue-based
//               reference model (RAS checks when PC_RAS_EN is defined).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_pc_unit;

    localparam logic [31:0] c_reset_vec = 32'h0000_0000;
    localparam logic [31:0] c_trap_vec  = 32'h0000_0100;
    localparam int          c_ras_depth = 4;

    logic        clk = 1'b0;
    logic        clr_n;
    logic        stall, redirect_en, trap_en, halt_req, resume;
    logic [31:0] redirect_pc;
    logic [31:0] pc, pc_next_seq;
    logic        pc_valid, misalign;
`ifdef PC_RAS_EN
    logic        ras_call, ras_ret, ras_empty;
`endif

    always #5 clk = ~clk;

    pc_unit #(
        .XLEN         (32),
        .INC          (4),
        .RESET_VECTOR (c_reset_vec),
        .TRAP_VECTOR  (c_trap_vec),
        .ALIGN_BITS   (2),
        .RAS_DEPTH    (c_ras_depth)
    ) dut (
        .clk          (clk),
        .clr_n        (clr_n),
        .stall        (stall),
        .redirect_en  (redirect_en),
        .redirect_pc  (redirect_pc),
        .trap_en      (trap_en),
        .halt_req     (halt_req),
        .resume       (resume),
        .pc           (pc),
        .pc_next_seq  (pc_next_seq),
        .pc_valid     (pc_valid),
        .misalign     (misalign)
`ifdef PC_RAS_EN
        ,
        .ras_call     (ras_call),
        .ras_ret      (ras_ret),
        .ras_empty    (ras_empty)
`endif
    );

    typedef enum {M_BOOT, M_RUN, M_HALT} mstate_t;
    mstate_t     m_state;
    logic [31:0] m_pc;
    logic        m_mis;
    logic [31:0] m_ras [$];
    int          n_vec = 0;
    int          n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_state = M_BOOT;
        m_pc    = c_reset_vec;
        m_mis   = 1'b0;
        m_ras.delete();
    endtask

    task automatic check_all();
        chk("pc", pc, m_pc);
        chk("pc_valid", {31'd0, pc_valid}, {31'd0, m_state == M_RUN});
        chk("misalign", {31'd0, misalign}, {31'd0, m_mis});
        chk("pc_next_seq", pc_next_seq, m_pc + 32'd4);
`ifdef PC_RAS_EN
        chk("ras_empty", {31'd0, ras_empty}, {31'd0, m_ras.size() == 0});
`endif
    endtask

    // One falling edge with the given inputs, then model update and checks.
    task automatic step(input bit tr, input bit rd, input logic [31:0] rp,
                        input bit hq, input bit rs, input bit st,
                        input bit cl, input bit rt);
        logic [31:0] top;
        trap_en = tr; redirect_en = rd; redirect_pc = rp;
        halt_req = hq; resume = rs; stall = st;
`ifdef PC_RAS_EN
        ras_call = cl; ras_ret = rt;
`endif
        @(negedge clk);
        #1;
        m_mis = 1'b0;
        if (tr) begin
            m_state = M_RUN;
            m_pc    = c_trap_vec;
            m_ras.delete();
        end else if (m_state == M_BOOT) begin
            m_state = M_RUN;
        end else if (m_state == M_HALT) begin
            if (rs) m_state = M_RUN;
        end else if (hq) begin
            m_state = M_HALT;
        end else if (rd) begin
            if (rp % 4 != 0) begin
                m_pc  = c_trap_vec;
                m_mis = 1'b1;
            end else begin
                m_pc = rp;
            end
`ifdef PC_RAS_EN
        end else if (rt && m_ras.size() > 0) begin
            top = m_ras.pop_back();
            if (cl) m_ras.push_back(m_pc + 32'd4);
            m_pc = top;
`endif
        end else if (!st) begin
`ifdef PC_RAS_EN
            if (cl) begin
                if (m_ras.size() == c_ras_depth) void'(m_ras.pop_front());
                m_ras.push_back(m_pc + 32'd4);
            end
`endif
            m_pc = m_pc + 32'd4;
        end
        top = '0;
        check_all();
    endtask

    task automatic free_step();
        step(0, 0, 32'd0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        logic [31:0] saved_pc;
        clr_n = 1'b0;
        stall = 0; redirect_en = 0; redirect_pc = '0; trap_en = 0; halt_req = 0; resume = 0;
`ifdef PC_RAS_EN
        ras_call = 0; ras_ret = 0;
`endif
        m_reset();
        #2;
        chk("reset_pc", pc, 32'h0);
        chk("reset_valid", {31'd0, pc_valid}, 32'd0);
        chk("reset_misalign", {31'd0, misalign}, 32'd0);
        @(posedge clk);
        clr_n = 1'b1;

        // Boot bubble then sequential fetch.
        free_step();
        chk("boot_pc", pc, 32'h0);
        chk("boot_valid", {31'd0, pc_valid}, 32'd1);
        free_step();
        chk("seq_pc4", pc, 32'h4);
        free_step();
        chk("seq_pc8", pc, 32'h8);

        // Redirect beats stall; misaligned target vectors to trap.
        step(0, 1, 32'h40, 0, 0, 1, 0, 0);
        chk("redir_40", pc, 32'h40);
        chk("redir_40_mis", {31'd0, misalign}, 32'd0);
        step(0, 0, 32'h0, 0, 0, 1, 0, 0);
        chk("stall_hold", pc, 32'h40);
        step(0, 1, 32'h42, 0, 0, 0, 0, 0);
        chk("mis_pc", pc, 32'h100);
        chk("mis_pulse", {31'd0, misalign}, 32'd1);
        free_step();
        chk("mis_clear", {31'd0, misalign}, 32'd0);

        // HALT ignores redirect; trap with redirect forces RUN at the vector.
        step(0, 1, 32'h200, 1, 0, 0, 0, 0);
        chk("halt_valid", {31'd0, pc_valid}, 32'd0);
        step(0, 1, 32'h300, 0, 0, 0, 0, 0);
        step(1, 1, 32'h300, 0, 0, 0, 0, 0);
        chk("halt_trap_pc", pc, 32'h100);
        chk("halt_trap_valid", {31'd0, pc_valid}, 32'd1);
        step(0, 0, 32'h0, 1, 0, 0, 0, 0);
        step(0, 0, 32'h0, 0, 1, 0, 0, 0);
        chk("resume_valid", {31'd0, pc_valid}, 32'd1);

        // Wrap at the top of the address space.
        step(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0);
        free_step();
        chk("wrap_pc", pc, 32'h0);

`ifdef PC_RAS_EN
        step(0, 1, 32'h10, 0, 0, 0, 0, 0);
        step(0, 0, 32'h0, 0, 0, 0, 1, 0);
        step(0, 1, 32'h80, 0, 0, 0, 0, 0);
        free_step();
        step(0, 0, 32'h0, 0, 0, 0, 0, 1);
        chk("ras_ret_pc", pc, 32'h14);
        for (int i = 0; i < 5; i++) step(0, 0, 32'h0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 32'h0, 0, 0, 0, 0, 1);
        chk("ras_drained", {31'd0, ras_empty}, 32'd1);
        saved_pc = pc;
        step(0, 0, 32'h0, 0, 0, 0, 0, 1);
        chk("ras_empty_ret", pc, saved_pc + 32'd4);
`endif
        saved_pc = '0;

        // Asynchronous reset mid-run, without a clock edge.
        free_step();
        clr_n = 1'b0;
        #1;
        m_reset();
        chk("async_rst_pc", pc, c_reset_vec);
        chk("async_rst_valid", {31'd0, pc_valid}, 32'd0);
        @(posedge clk);
        clr_n = 1'b1;

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 24) == 0,
                 $urandom_range(0, 3) == 0,
                 ($urandom_range(0, 5) == 0) ? 32'($urandom) : (32'($urandom) & 32'hFFFF_FFFC),
                 $urandom_range(0, 14) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 3) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
